dwise_addr_scheduler: RTL and testbench

DWISE_ADDR_SCHEDULER -- requirements
Module: dwise_addr_scheduler

---
 rtl/dwise_addr_scheduler_pkg.sv | 18 +
 rtl/dwise_window_counter.sv | 62 ++++++
 rtl/dwise_addr_scheduler.sv | 150 +++++++++++++++
 tb/tb_dwise_addr_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dwise_addr_scheduler_pkg.sv
// Shared types and helpers for the depthwise window address scheduler.
package dwise_addr_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // Number of valid window origins along one spatial axis (no padding, stride 1).
  function automatic int unsigned calc_o_size(input int unsigned i_size,
                                              input int unsigned k_size);
    return i_size - k_size + 32'd1;
  endfunction

endpackage

// File: rtl/dwise_window_counter.sv
// Nested y/x/c window counter: y fastest, c outermost, each wrapping at its limit.
module dwise_window_counter #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_lim_xy,
  input  logic [ADDR_WIDTH-1:0] i_lim_c,
  output logic [ADDR_WIDTH-1:0] o_y,
  output logic [ADDR_WIDTH-1:0] o_x,
  output logic [ADDR_WIDTH-1:0] o_c,
  output logic                  o_last
);

  localparam logic [ADDR_WIDTH-1:0] One = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] y_q, y_d, x_q, x_d, c_q, c_d;
  logic                  y_wrap, x_wrap, c_wrap;

  assign y_wrap = (y_q == i_lim_xy - One);
  assign x_wrap = (x_q == i_lim_xy - One);
  assign c_wrap = (c_q == i_lim_c - One);
  assign o_last = y_wrap && x_wrap && c_wrap;

  always_comb begin
    y_d = y_q;
    x_d = x_q;
    c_d = c_q;
    if (i_clear) begin
      y_d = '0;
      x_d = '0;
      c_d = '0;
    end else if (i_en) begin
      y_d = y_wrap ? '0 : y_q + One;
      if (y_wrap) begin
        x_d = x_wrap ? '0 : x_q + One;
        if (x_wrap) begin
          c_d = c_wrap ? '0 : c_q + One;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y_q <= '0;
      x_q <= '0;
      c_q <= '0;
    end else begin
      y_q <= y_d;
      x_q <= x_d;
      c_q <= c_d;
    end
  end

  assign o_y = y_q;
  assign o_x = x_q;
  assign o_c = c_q;

endmodule

// File: rtl/dwise_addr_scheduler.sv
// Sequences depthwise-conv window origins (y, x, c) to an external address generator,
// rotating a one-hot PE row id per issued window.
module dwise_addr_scheduler
  import dwise_addr_scheduler_pkg::*;
#(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned KERNEL_SIZE = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_i_size,
  input  logic [ADDR_WIDTH-1:0]   i_i_c_size,
  input  logic [ADDR_WIDTH-1:0]   i_start_addr,
  input  logic                    i_stall,
  output logic                    o_en,
  output logic                    o_reg_clear,
  output logic [ADDR_WIDTH-1:0]   o_o_x,
  output logic [ADDR_WIDTH-1:0]   o_o_y,
  output logic [ADDR_WIDTH-1:0]   o_i_c,
  output logic [ADDR_WIDTH-1:0]   o_i_size,
  output logic [ADDR_WIDTH-1:0]   o_i_c_size,
  output logic [ADDR_WIDTH-1:0]   o_start_addr,
  output logic [ROWS-1:0]         o_row_id,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [3*ADDR_WIDTH-1:0] o_count
);

  localparam int unsigned           CountW   = 3 * ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] KSize    = ADDR_WIDTH'(KERNEL_SIZE);
  localparam logic [ROWS-1:0]       RowFirst = ROWS'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_size_q, i_size_d, c_size_q, c_size_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d, o_size_q, o_size_d;
  logic [ROWS-1:0]       row_q, row_d;
  logic [CountW-1:0]     count_q, count_d;
  logic                  err_q, err_d;
  logic                  bad_cfg, launch, issue, last;

  assign bad_cfg = (i_i_size < KSize) || (i_i_c_size == '0);
  assign launch  = (state_q == StIdle) && i_start && !bad_cfg;
  assign issue   = (state_q == StIssue) && !i_stall;

  // Counter holds on the final window so the outputs keep the last origin after the job.
  dwise_window_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (launch),
    .i_en    (issue && !last),
    .i_lim_xy(o_size_q),
    .i_lim_c (c_size_q),
    .o_y     (o_o_y),
    .o_x     (o_o_x),
    .o_c     (o_i_c),
    .o_last  (last)
  );

  always_comb begin
    state_d      = state_q;
    i_size_d     = i_size_q;
    c_size_d     = c_size_q;
    start_addr_d = start_addr_q;
    o_size_d     = o_size_q;
    row_d        = row_q;
    count_d      = count_q;
    err_d        = 1'b0;
    o_en         = 1'b0;
    o_reg_clear  = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (bad_cfg) begin
            err_d = 1'b1;
          end else begin
            i_size_d     = i_i_size;
            c_size_d     = i_i_c_size;
            start_addr_d = i_start_addr;
            o_size_d     = ADDR_WIDTH'(calc_o_size(32'(i_i_size), KERNEL_SIZE));
            row_d        = RowFirst;
            count_d      = '0;
            state_d      = StClear;
          end
        end
      end
      StClear: begin
        o_reg_clear = 1'b1;
        o_busy      = 1'b1;
        state_d     = StIssue;
      end
      StIssue: begin
        o_busy = 1'b1;
        o_en   = !i_stall;
        if (issue) begin
          row_d   = {row_q[ROWS-2:0], row_q[ROWS-1]};
          count_d = count_q + CountW'(1);
          if (last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        o_busy  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      i_size_q     <= '0;
      c_size_q     <= '0;
      start_addr_q <= '0;
      o_size_q     <= '0;
      row_q        <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_size_q     <= i_size_d;
      c_size_q     <= c_size_d;
      start_addr_q <= start_addr_d;
      o_size_q     <= o_size_d;
      row_q        <= row_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign o_i_size     = i_size_q;
  assign o_i_c_size   = c_size_q;
  assign o_start_addr = start_addr_q;
  assign o_row_id     = row_q;
  assign o_count      = count_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_dwise_addr_scheduler.sv
// Self-checking bench: table of job configurations, stall/reset/restart sequences and
// randomized jobs, compared against a loop-nest reference model.
module tb_dwise_addr_scheduler;

  localparam int ROWS = 4;
  localparam int AW   = 6;
  localparam int K    = 3;

  logic            clk = 1'b0;
  logic            rst, start, stall;
  logic [AW-1:0]   isz, csz, saddr;
  logic            o_en, o_reg_clear, o_busy, o_done, o_err;
  logic [AW-1:0]   o_o_x, o_o_y, o_i_c, o_i_size, o_i_c_size, o_start_addr;
  logic [ROWS-1:0] o_row_id;
  logic [3*AW-1:0] o_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {int c; int x; int y;} win_t;
  typedef struct {int isz; int csz; bit err; int nwin;} vec_t;

  win_t model_q[$];

  dwise_addr_scheduler #(
    .ROWS(ROWS), .ADDR_WIDTH(AW), .KERNEL_SIZE(K)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_i_size(isz), .i_i_c_size(csz),
    .i_start_addr(saddr), .i_stall(stall), .o_en(o_en), .o_reg_clear(o_reg_clear),
    .o_o_x(o_o_x), .o_o_y(o_o_y), .o_i_c(o_i_c), .o_i_size(o_i_size),
    .o_i_c_size(o_i_c_size), .o_start_addr(o_start_addr), .o_row_id(o_row_id),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_count(o_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: enumerate windows c-outer, x-middle, y-inner.
  function automatic void build_model(input int i_size, input int c_size);
    int osz = i_size - K + 1;
    model_q.delete();
    for (int c = 0; c < c_size; c++)
      for (int x = 0; x < osz; x++)
        for (int y = 0; y < osz; y++) begin
          win_t w;
          w.c = c; w.x = x; w.y = y;
          model_q.push_back(w);
        end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({o_en, o_reg_clear, o_busy, o_done, o_err}), 0);
    check({tag, "_xyc"}, 64'({o_o_x, o_o_y, o_i_c}), 0);
    check({tag, "_cfg"}, 64'({o_i_size, o_i_c_size, o_start_addr}), 0);
    check({tag, "_row"}, 64'(o_row_id), 0);
    check({tag, "_count"}, 64'(o_count), 0);
  endtask

  task automatic launch(input int i_size, input int c_size, input int sa);
    step();
    start = 1'b1;
    isz   = AW'(i_size);
    csz   = AW'(c_size);
    saddr = AW'(sa);
    #1;
    step();
    start = 1'b0;
    #1;
  endtask

  // mode 0: no stall, 1: random stall + random i_start during issue, 2: 3-cycle stall at window 2
  task automatic run_job(input int i_size, input int c_size, input int mode,
                         input bit exp_err, input int exp_nwin);
    int  n, k, stalls, cyc, stall_left, budget, sa;
    bit  done;
    k = 0; stalls = 0; cyc = 0; stall_left = 3; done = 1'b0;
    sa = int'($urandom_range(0, (1 << AW) - 1));
    launch(i_size, c_size, sa);
    if (exp_err) begin
      check("err_pulse", 64'(o_err), 1);
      check("err_busy", 64'({o_busy, o_reg_clear, o_en}), 0);
      step();
      check("err_one_cycle", 64'(o_err), 0);
      check("err_no_en", 64'({o_busy, o_en}), 0);
      return;
    end
    build_model(i_size, c_size);
    n = model_q.size();
    budget = 4 * n + 20;
    check("clear_pulse", 64'({o_reg_clear, o_busy, o_en}), 3'b110);
    check("clear_row", 64'(o_row_id), 1);
    check("clear_count", 64'(o_count), 0);
    check("clear_xyc", 64'({o_o_x, o_o_y, o_i_c}), 0);
    check("cfg_latch", 64'({o_i_size, o_i_c_size, o_start_addr}),
          64'({isz, csz, AW'(sa)}));
    while (!done && cyc < budget) begin
      step();
      cyc++;
      stall = 1'b0;
      start = 1'b0;
      if (k < n) begin
        case (mode)
          1: begin
            stall = ($urandom_range(0, 3) == 0);
            start = $urandom_range(0, 1) == 1;
          end
          2: stall = (k == 2) && (stall_left > 0);
          default: stall = 1'b0;
        endcase
      end
      #1;
      if (k < n) begin
        check("en_vs_stall", 64'(o_en), 64'(!stall));
        check("win_c", 64'(o_i_c), 64'(model_q[k].c));
        check("win_x", 64'(o_o_x), 64'(model_q[k].x));
        check("win_y", 64'(o_o_y), 64'(model_q[k].y));
        check("win_row", 64'(o_row_id), 64'(1 << (k % ROWS)));
        check("win_count", 64'(o_count), 64'(k));
        if (stall) begin
          stalls++;
          stall_left--;
        end
        if (o_en) k++;
      end else if (o_done) begin
        done = 1'b1;
        check("done_cycle", 64'(cyc), 64'(n + stalls + 2));
        check("done_count", 64'(o_count), 64'(exp_nwin));
        check("done_busy", 64'({o_busy, o_en}), 0);
      end else begin
        check("drain_state", 64'({o_busy, o_en, o_reg_clear}), 3'b100);
      end
    end
    if (!done) check("done_timeout", 0, 1);
    check("windows_issued", 64'(k), 64'(exp_nwin));
    if (mode == 2) check("stall_cycles", 64'(stalls), 3);
    step();
    check("idle_after", 64'({o_busy, o_done, o_en}), 0);
    check("count_hold", 64'(o_count), 64'(exp_nwin));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{isz: 4, csz: 2, err: 1'b0, nwin: 8};
    vecs[1] = '{isz: 5, csz: 1, err: 1'b0, nwin: 9};
    vecs[2] = '{isz: 3, csz: 3, err: 1'b0, nwin: 3};
    vecs[3] = '{isz: 2, csz: 1, err: 1'b1, nwin: 0};
    vecs[4] = '{isz: 4, csz: 0, err: 1'b1, nwin: 0};
    vecs[5] = '{isz: 6, csz: 2, err: 1'b0, nwin: 32};
    vecs[6] = '{isz: 0, csz: 5, err: 1'b1, nwin: 0};

    rst = 1'b1; start = 1'b0; stall = 1'b0; isz = '0; csz = '0; saddr = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    check("reset_no_pulse", 64'({o_done, o_err}), 0);

    foreach (vecs[i]) run_job(vecs[i].isz, vecs[i].csz, 0, vecs[i].err, vecs[i].nwin);

    // Three-cycle stall at window 2.
    run_job(5, 1, 2, 1'b0, 9);

    // Reset in the middle of ISSUE, then a fresh full job.
    launch(5, 2, 7);
    repeat (5) step();
    check("pre_reset_busy", 64'(o_busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    run_job(5, 2, 0, 1'b0, 18);

    // Randomized jobs with stalls and spurious i_start during issue.
    for (int j = 0; j < 6; j++) begin
      int ri, rc;
      ri = int'($urandom_range(3, 10));
      rc = int'($urandom_range(1, 4));
      run_job(ri, rc, 1, 1'b0, rc * (ri - K + 1) * (ri - K + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
